// File: rtl/double_trouble_sweeper.sv
// Sweep controller that walks all 16 inputs of the "at least two high" evaluator and scores it.
// Optional stop-at-first-mismatch behaviour is enabled by defining DTS_STOP_ON_FAIL_EN.
module double_trouble_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] drv,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [4:0] pass_cnt,
  output logic [4:0] fail_cnt,
  output logic [3:0] first_fail_vec,
  output logic       first_fail_valid
);

  localparam int unsigned VEC_W = 4;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned SET_W = 4;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] VEC_LAST    = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]   pass_d, fail_d;
  logic [VEC_W-1:0]   ffv_d;
  logic               ffvalid_d;
  logic               aborted_d;
  logic [VEC_W-1:0]   drv_d;
  logic               busy_d;
  logic               done_d;

  logic [2:0]         ones_c;
  logic               golden_c;
  logic               match_c;

  // Golden model: output is high when at least two inputs are high.
  assign ones_c   = 3'(vec_q[0]) + 3'(vec_q[1]) + 3'(vec_q[2]) + 3'(vec_q[3]);
  assign golden_c = (ones_c >= 3'd2);
  assign match_c  = (dut_out == golden_c);

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      vec_q            <= '0;
      settle_q         <= '0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      aborted          <= 1'b0;
      drv              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      state_q          <= state_d;
      vec_q            <= vec_d;
      settle_q         <= settle_d;
      pass_cnt         <= pass_d;
      fail_cnt         <= fail_d;
      first_fail_vec   <= ffv_d;
      first_fail_valid <= ffvalid_d;
      aborted          <= aborted_d;
      drv              <= drv_d;
      busy             <= busy_d;
      done             <= done_d;
    end
  end

  // Next-state and result bookkeeping.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    settle_d  = settle_q;
    pass_d    = pass_cnt;
    fail_d    = fail_cnt;
    ffv_d     = first_fail_vec;
    ffvalid_d = first_fail_valid;
    aborted_d = aborted;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = DRIVE;
          vec_d     = '0;
          settle_d  = '0;
          pass_d    = '0;
          fail_d    = '0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
          aborted_d = 1'b0;
        end
      end

      DRIVE: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else begin
          settle_d = settle_q + SET_W'(1);
          if (settle_q == SETTLE_LAST) begin
            state_d = SAMPLE;
          end
        end
      end

      SAMPLE: begin
        // Abort takes priority over both scoring and the final-vector exit.
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else begin
          if (match_c) begin
            pass_d = pass_cnt + CNT_W'(1);
          end else begin
            fail_d = fail_cnt + CNT_W'(1);
            if (!first_fail_valid) begin
              ffv_d     = vec_q;
              ffvalid_d = 1'b1;
            end
          end

          if (vec_q == VEC_LAST) begin
            state_d = DONE;
          end
`ifdef DTS_STOP_ON_FAIL_EN
          else if (!match_c) begin
            state_d = DONE;
          end
`endif
          else begin
            state_d  = DRIVE;
            vec_d    = vec_q + VEC_W'(1);
            settle_d = '0;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, registered alongside the state.
  always_comb begin
    drv_d  = '0;
    busy_d = 1'b0;
    done_d = 1'b0;

    case (state_d)
      DRIVE, SAMPLE: begin
        drv_d  = vec_d;
        busy_d = 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        drv_d  = '0;
      end
    endcase
  end

endmodule

// File: doc/double_trouble_sweeper.md
# double_trouble_sweeper

Self-checking sweep controller for the 4-input "at least two high" majority block (DOUBLE_TROUBLE). On a start pulse it drives all 16 input combinations into the evaluator in ascending order. It waits a programmable settle time for each combination, samples the evaluator's output and compares it against an internal golden model. It accumulates pass and fail counts and latches the first failing vector. It sits between a test or BIST host and the shared evaluator.

## Interface
Parameters:
- SETTLE_CYCLES, default 1: cycles each vector is held before its sample cycle. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a sweep; honoured only in IDLE.
- abort  in  1  cancel a running sweep; honoured only in DRIVE/SAMPLE.
- drv  out  4  vector to evaluator; bit i feeds evaluator input in_i.
- dut_out  in  1  evaluator output.
- busy  out  1  high in DRIVE and SAMPLE.
- done  out  1  one-cycle pulse in DONE.
- aborted  out  1  sticky; set by abort, cleared by next accepted start or rst.
- pass_cnt  out  5  vectors that matched (0..16).
- fail_cnt  out  5  vectors that mismatched (0..16).
- first_fail_vec  out  4  first mismatching vector; 0 when none.
- first_fail_valid  out  1  high once any mismatch is recorded.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- Reset values: state=IDLE, drv=0, busy=0, done=0, aborted=0, pass_cnt=0, fail_cnt=0, first_fail_vec=0, first_fail_valid=0, vector register=0, settle counter=0.
- IDLE:
  - drv=0.
  - If start=1, go to DRIVE with vector=0 and settle counter=0.
  - At the same time, clear the counts, the first-fail fields and aborted.
  - abort is ignored in IDLE.
- DRIVE:
  - drv=vector and the settle counter increments each cycle.
  - After SETTLE_CYCLES cycles in DRIVE, go to SAMPLE.
- SAMPLE (one cycle):
  - drv is still the vector; golden = popcount(vector) >= 2.
  - dut_out==golden: pass_cnt++.
  - dut_out!=golden: fail_cnt++. If first_fail_valid=0, latch first_fail_vec=vector and set first_fail_valid.
  - If vector==15, go to DONE. Otherwise vector+1, clear the settle counter and go to DRIVE.
- DONE (one cycle): done=1, drv=0, then go to IDLE.
- Results hold until the next accepted start or rst.
- abort=1 in DRIVE or SAMPLE:
  - Go to IDLE next cycle and set aborted; no done pulse.
  - A SAMPLE cycle carrying abort does not update the counters.
  - abort wins over the vector==15 transition.
- start while busy or in DONE is ignored; nothing is queued.
- rst at any point, including mid-sweep, restores all reset values on the next edge.
- Expected golden results: 11 of the 16 vectors give 1. Vectors 0, 1, 2, 4 and 8 give 0.

## Timing
- Start is sampled at cycle 0. DRIVE for vector 0 begins at cycle 1.
- Vector v occupies cycles 1+v·(S+1) .. (v+1)·(S+1), with S=SETTLE_CYCLES. Its last cycle is SAMPLE.
- DONE, and therefore the done pulse, occurs at cycle 1+16·(S+1). With S=1 that is cycle 33.
- Counters update on the edge that ends the SAMPLE cycle, so they are visible one cycle later.
- Final counts are stable in the DONE cycle.
- busy is 0 in the DONE cycle. A new start is first accepted the cycle after DONE.

## Configuration
- Macro: DTS_STOP_ON_FAIL_EN.
- Defined:
  - A SAMPLE with a mismatch goes straight to DONE, even if vector<15.
  - The remaining vectors are not driven, so pass_cnt+fail_cnt equals the mismatching vector + 1.
- Undefined: all 16 vectors always run and pass_cnt+fail_cnt=16 on completion.

## Test plan
- Correct evaluator model, S=1, start at cycle 0:
  - Required: done at cycle 33, pass_cnt=16, fail_cnt=0, first_fail_valid=0, busy high for cycles 1..32.
- Evaluator stuck at 0, macro undefined:
  - Required: pass_cnt=5, fail_cnt=11, first_fail_vec=3, first_fail_valid=1.
- Evaluator stuck at 1, S=1:
  - Macro undefined: pass_cnt=11, fail_cnt=5, first_fail_vec=0.
  - Macro defined: done at cycle 3, pass_cnt=0, fail_cnt=1.
- Correct model, abort asserted at cycle 10 (S=1):
  - Required: IDLE at cycle 11, drv=0, aborted=1, no done pulse, pass_cnt=4.
  - A later start clears aborted and completes normally.
- start re-pulsed at cycle 5 while busy:
  - Required: ignored, done still at cycle 33.
- rst at cycle 12:
  - Required: all outputs at reset values at cycle 13.
- S=3:
  - Required: each vector held 4 cycles, done at cycle 65.
